// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and defaults for the write-back data cache controller.
//   cache_st_e           controller FSM state encoding
//   WORDS_PER_BLOCK_DEF  default number of words per cache line
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_HIT = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_MERGE  = 3'd4,
        ST_RESP   = 3'd5
    } cache_st_e;

    localparam int unsigned WORDS_PER_BLOCK_DEF = 32'd4;

endpackage : cache_pkg

// File: rtl/cache_beat_ctr.sv
// -----------------------------------------------------------------------------
// cache_beat_ctr
// Word-within-line counter shared by the writeback and fill phases.
// It wraps naturally because the line size is a power of two.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   clr   in   force the count to 0 (start of a miss)
//   inc   in   advance one beat (memory acknowledged the current word)
//   cnt   out  current beat index
//   last  out  count is on the final word of the line
// -----------------------------------------------------------------------------
module cache_beat_ctr #(
    parameter int unsigned BEAT_W = 32'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] cnt,
    output logic              last
);

    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_d;

    // Next-count selection: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + BEAT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = &cnt_q;

endmodule : cache_beat_ctr

// File: rtl/cache_ctrl_wb.sv
// -----------------------------------------------------------------------------
// cache_ctrl_wb
// Write-back, write-allocate cache controller between the MEM stage and main
// memory. A miss writes back the dirty victim line (WB) if needed. It then
// fills the line (FILL) one word per req/ack beat. The miss finishes with
// either a read response (RESP) or a merge of the buffered store word (MERGE).
//
// Optional feature macro: CACHE_CTRL_PERF_EN builds saturating hit/miss/
// writeback counters. Without it the counter ports read constant 0.
//
// Ports:
//   clk, rst (async active-low)
//   cpu_rd, cpu_wr, hit, dirty          pipeline request and tag-array status
//   stall                               pipeline hold (combinational)
//   cache_dataReady                     one-cycle read-data-valid pulse
//   cache_we_word, cache_we_block       cache data write enables
//   tag_we, set_dirty                   tag/valid/dirty update
//   WriteData_Buffer, CacheLdFromBuffer store-data buffer control
//   beat                                word index of the current transfer
//   mem_req, mem_we, mem_ack            per-beat memory handshake
//   hit_cnt, miss_cnt, wb_cnt           performance counters
// -----------------------------------------------------------------------------
module cache_ctrl_wb
    import cache_pkg::*;
#(
    parameter  int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter  int unsigned PERF_W          = 32'd32,
    localparam int unsigned BEAT_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              hit,
    input  logic              dirty,
    output logic              stall,
    output logic              cache_dataReady,
    output logic              cache_we_word,
    output logic              cache_we_block,
    output logic              tag_we,
    output logic              set_dirty,
    output logic              WriteData_Buffer,
    output logic              CacheLdFromBuffer,
    output logic [BEAT_W-1:0] beat,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [PERF_W-1:0] hit_cnt,
    output logic [PERF_W-1:0] miss_cnt,
    output logic [PERF_W-1:0] wb_cnt
);

    cache_st_e state_q;
    cache_st_e state_d;
    logic      op_is_wr_q;
    logic      op_is_wr_d;
    logic      mem_req_q;
    logic      mem_req_d;
    logic      mem_we_q;
    logic      mem_we_d;
    logic      data_ready_q;
    logic      data_ready_d;
    logic      merge_q;
    logic      merge_d;

    logic      idle_s;
    logic      fill_s;
    logic      wb_s;
    logic      req_s;
    logic      rd_hit_s;
    logic      wr_hit_s;
    logic      miss_s;
    logic      miss_wr_s;
    logic      beat_adv_s;
    logic      beat_last_s;

    assign idle_s    = (state_q == ST_IDLE);
    assign fill_s    = (state_q == ST_FILL);
    assign wb_s      = (state_q == ST_WB);
    assign req_s     = cpu_rd | cpu_wr;
    // A load takes priority; a simultaneous store is served once the load finishes.
    assign rd_hit_s  = idle_s & cpu_rd & hit;
    assign wr_hit_s  = idle_s & ~cpu_rd & cpu_wr & hit;
    assign miss_s    = idle_s & req_s & ~hit;
    assign miss_wr_s = cpu_wr & ~cpu_rd;
    // Acks only count while a beat is actually requested.
    assign beat_adv_s = mem_req_q & mem_ack;

    cache_beat_ctr #(
        .BEAT_W (BEAT_W)
    ) u_beat_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (miss_s),
        .inc  (beat_adv_s),
        .cnt  (beat),
        .last (beat_last_s)
    );

    // Next-state and miss-type capture.
    always_comb begin
        state_d    = state_q;
        op_is_wr_d = op_is_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_hit_s) begin
                    state_d = ST_RD_HIT;
                end else if (miss_s) begin
                    op_is_wr_d = miss_wr_s;
                    state_d    = dirty ? ST_WB : ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_HIT: begin
                state_d = ST_IDLE;
            end
            ST_WB: begin
                if (beat_adv_s && beat_last_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_FILL: begin
                if (beat_adv_s && beat_last_s) begin
                    state_d = op_is_wr_q ? ST_MERGE : ST_RESP;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_MERGE: begin
                state_d = ST_IDLE;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs are decoded from the next state so they are registered.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        data_ready_d = 1'b0;
        merge_d      = 1'b0;
        case (state_d)
            ST_WB: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
            end
            ST_FILL: begin
                mem_req_d = 1'b1;
            end
            ST_RD_HIT: begin
                data_ready_d = 1'b1;
            end
            ST_RESP: begin
                data_ready_d = 1'b1;
            end
            ST_MERGE: begin
                merge_d = 1'b1;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Controller FSM state, latched miss type and registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_is_wr_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            data_ready_q <= 1'b0;
            merge_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_is_wr_q   <= op_is_wr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            data_ready_q <= data_ready_d;
            merge_q      <= merge_d;
        end
    end

    // Request-decoded outputs are qualified by rst so every output is 0 while
    // reset is asserted, even if the pipeline keeps a request high.
    assign stall             = rst & (~idle_s | (req_s & ~hit & idle_s) | (cpu_rd & idle_s));
    assign cache_we_word     = merge_q | (rst & wr_hit_s);
    assign set_dirty         = merge_q | (rst & wr_hit_s);
    assign WriteData_Buffer  = rst & miss_s & miss_wr_s;
    assign CacheLdFromBuffer = merge_q;
    assign cache_dataReady   = data_ready_q;
    assign mem_req           = mem_req_q;
    assign mem_we            = mem_we_q;
    assign cache_we_block    = fill_s & beat_adv_s;
    assign tag_we            = fill_s & beat_adv_s & beat_last_s;

`ifdef CACHE_CTRL_PERF_EN
    logic              hit_ev_s;
    logic              wb_ev_s;
    logic [PERF_W-1:0] hit_cnt_q;
    logic [PERF_W-1:0] hit_cnt_d;
    logic [PERF_W-1:0] miss_cnt_q;
    logic [PERF_W-1:0] miss_cnt_d;
    logic [PERF_W-1:0] wb_cnt_q;
    logic [PERF_W-1:0] wb_cnt_d;

    assign hit_ev_s = rd_hit_s | wr_hit_s;
    assign wb_ev_s  = miss_s & dirty;
    // The victim line is only written back on the transition into WB.
    logic unused_wb_s;
    assign unused_wb_s = wb_s;

    // Saturating counter updates.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (hit_ev_s && (hit_cnt_q != {PERF_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + PERF_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_s && (miss_cnt_q != {PERF_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + PERF_W'(1);
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
        if (wb_ev_s && (wb_cnt_q != {PERF_W{1'b1}})) begin
            wb_cnt_d = wb_cnt_q + PERF_W'(1);
        end else begin
            wb_cnt_d = wb_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    logic unused_wb_s;
    assign unused_wb_s = wb_s;
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign wb_cnt   = '0;
`endif

endmodule : cache_ctrl_wb

// File: tb/tb_cache_ctrl_wb.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_wb
// Scoreboard bench for cache_ctrl_wb (WORDS_PER_BLOCK=4). Each driven cycle
// pushes the expected output vector; a negedge monitor pops and compares.
// Output vector layout (MSB..LSB):
//   stall, dataReady, we_word, we_block, tag_we, set_dirty, wdata_buf,
//   ld_from_buf, mem_req, mem_we, beat[1:0]
// -----------------------------------------------------------------------------
module tb_cache_ctrl_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, hit, dirty, mem_ack;
    logic        stall, cache_dataReady, cache_we_word, cache_we_block;
    logic        tag_we, set_dirty, WriteData_Buffer, CacheLdFromBuffer;
    logic [1:0]  beat;
    logic        mem_req, mem_we;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;
    int          exp_wb   = 0;

    typedef struct {
        string      tag;
        logic [11:0] vec;
    } exp_t;

    exp_t sb_q[$];

    logic [11:0] obs_vec;
    assign obs_vec = {stall, cache_dataReady, cache_we_word, cache_we_block, tag_we, set_dirty,
                      WriteData_Buffer, CacheLdFromBuffer, mem_req, mem_we, beat};

    cache_ctrl_wb #(
        .WORDS_PER_BLOCK (4),
        .PERF_W          (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_rd            (cpu_rd),
        .cpu_wr            (cpu_wr),
        .hit               (hit),
        .dirty             (dirty),
        .stall             (stall),
        .cache_dataReady   (cache_dataReady),
        .cache_we_word     (cache_we_word),
        .cache_we_block    (cache_we_block),
        .tag_we            (tag_we),
        .set_dirty         (set_dirty),
        .WriteData_Buffer  (WriteData_Buffer),
        .CacheLdFromBuffer (CacheLdFromBuffer),
        .beat              (beat),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_ack           (mem_ack),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt),
        .wb_cnt            (wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ev(input logic st, input logic rdy, input logic wew,
                                       input logic web, input logic tw, input logic sd,
                                       input logic wdb, input logic cld, input logic mrq,
                                       input logic mwe, input logic [1:0] bt);
        return {st, rdy, wew, web, tw, sd, wdb, cld, mrq, mwe, bt};
    endfunction

    function automatic logic [31:0] perf_exp(input int v);
`ifdef CACHE_CTRL_PERF_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Scoreboard monitor: one expected vector per driven cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq(e.tag, {20'd0, obs_vec}, {20'd0, e.vec});
        end
    end

    // Drive one cycle of inputs (called at posedge+1) and queue its expectation.
    task automatic drv(input logic rd, input logic wr, input logic h, input logic d,
                       input logic ack, input logic [11:0] e, input string tag);
        exp_t x;
        cpu_rd  = rd;
        cpu_wr  = wr;
        hit     = h;
        dirty   = d;
        mem_ack = ack;
        x.tag   = tag;
        x.vec   = e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic load_hit(input string tag);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ev(1,0,0,0,0,0,0,0,0,0,2'd0), {tag, "_t0"});
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ev(1,1,0,0,0,0,0,0,0,0,2'd0), {tag, "_t1"});
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,2'd0), {tag, "_t2"});
        exp_hits++;
    endtask

    // Full miss: optional writeback, fill, then RESP or MERGE; gap = idle ack cycles per beat.
    task automatic miss_txn(input logic is_wr, input logic dty, input int gap, input string tag);
        logic rd;
        logic ack;
        rd = ~is_wr;
        drv(rd, is_wr, 1'b0, dty, 1'b1, ev(1,0,0,0,0,0,is_wr,0,0,0,2'd0), {tag, "_req"});
        if (dty) begin
            for (int i = 0; i < 4; i++) begin
                for (int g = 0; g <= gap; g++) begin
                    ack = (g == gap);
                    drv(rd, is_wr, 1'b0, dty, ack, ev(1,0,0,0,0,0,0,0,1,1,2'(i)), {tag, "_wb"});
                end
            end
            exp_wb++;
        end
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g <= gap; g++) begin
                ack = (g == gap);
                drv(rd, is_wr, 1'b0, dty, ack,
                    ev(1,0,0,ack,ack && (i == 3),0,0,0,1,0,2'(i)), {tag, "_fill"});
            end
        end
        if (is_wr) begin
            drv(rd, is_wr, 1'b0, dty, 1'b1, ev(1,0,1,0,0,1,0,1,0,0,2'd0), {tag, "_merge"});
        end else begin
            drv(rd, is_wr, 1'b0, dty, 1'b1, ev(1,1,0,0,0,0,0,0,0,0,2'd0), {tag, "_resp"});
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,2'd0), {tag, "_idle"});
        exp_miss++;
    endtask

    initial begin
        rst     = 1'b0;
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        hit     = 1'b0;
        dirty   = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {20'd0, obs_vec}, 32'd0);
        check_eq("reset_hit_cnt", hit_cnt, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        load_hit("ld_hit");
        miss_txn(1'b0, 1'b0, 0, "ld_miss_clean");
        miss_txn(1'b1, 1'b1, 0, "st_miss_dirty");
        miss_txn(1'b0, 1'b0, 3, "ld_miss_slow");

        // Zero-wait store hit.
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ev(0,0,1,0,0,1,0,0,0,0,2'd0), "st_hit_t0");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,2'd0), "st_hit_t1");
        exp_hits++;

        // Load and store together: load first, store after the response.
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,2'd0), "rdwr_t0");
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(1,1,0,0,0,0,0,0,0,0,2'd0), "rdwr_t1");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(0,0,1,0,0,1,0,0,0,0,2'd0), "rdwr_t2");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,0,0,0,2'd0), "rdwr_t3");
        exp_hits += 2;

        check_eq("perf_hit_cnt", hit_cnt, perf_exp(exp_hits));
        check_eq("perf_miss_cnt", miss_cnt, perf_exp(exp_miss));
        check_eq("perf_wb_cnt", wb_cnt, perf_exp(exp_wb));

        // Reset asserted during writeback beat 2.
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ev(1,0,0,0,0,0,0,0,0,0,2'd0), "rst_mid_req");
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ev(1,0,0,0,0,0,0,0,1,1,2'd0), "rst_mid_wb0");
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ev(1,0,0,0,0,0,0,0,1,1,2'd1), "rst_mid_wb1");
        begin
            exp_t x;
            x.tag = "rst_mid_wb2";
            x.vec = ev(1,0,0,0,0,0,0,0,1,1,2'd2);
            sb_q.push_back(x);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_async_outputs", {20'd0, obs_vec}, 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        exp_wb   = 0;
        check_eq("rst_async_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_held_outputs", {20'd0, obs_vec}, 32'd0);
        cpu_rd = 1'b0;
        dirty  = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;

        load_hit("post_rst_hit");
        miss_txn(1'b0, 1'b1, 1, "post_rst_dirty_ld");

        @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("final_hit_cnt", hit_cnt, perf_exp(exp_hits));
        check_eq("final_miss_cnt", miss_cnt, perf_exp(exp_miss));
        check_eq("final_wb_cnt", wb_cnt, perf_exp(exp_wb));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_ctrl_wb
